// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the CPU/video block-RAM arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VID  = 2'd2
    } owner_e;

    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_DATA_W   = 16;
    localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating CPU starvation counter; at_max forces the next contended grant to the CPU.
module arb_starve_counter
    import mem_arb_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [STARVE_CNT_W-1:0] MAX_V = STARVE_CNT_W'(MAX);

    logic [STARVE_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != MAX_V)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign at_max = (r_cnt == MAX_V);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester block-RAM arbiter (video priority, bounded CPU starvation), 3-stage pipeline.
// Optional statistics counters enabled by defining MEM_ARB_STATS_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [15:0]       cpu_stall_cnt,
    output logic [15:0]       vid_gnt_cnt
`endif
);

    logic w_cpu_win;
    logic w_vid_win;
    logic w_starve_max;
    logic w_starve_inc;
    logic w_starve_clr;

    owner_e            r_iss_own;
    logic              r_iss_we;
    logic [ADDR_W-1:0] r_iss_addr;
    logic [DATA_W-1:0] r_iss_wdata;
    owner_e            r_ret_own;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_vid_rdata;

    always_comb begin
        w_cpu_win    = cpu_req && (!vid_req || w_starve_max);
        w_vid_win    = vid_req && !w_cpu_win;
        w_starve_inc = cpu_req && !w_cpu_win;
        w_starve_clr = !cpu_req || w_cpu_win;
    end

    assign cpu_gnt = w_cpu_win;
    assign vid_gnt = w_vid_win;

    arb_starve_counter #(
        .MAX(STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .reset  (reset),
        .inc    (w_starve_inc),
        .clr    (w_starve_clr),
        .at_max (w_starve_max)
    );

    // Stage A: capture the winner; addr/wdata only load on a grant so idle cycles hold them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_iss_own   <= OWN_NONE;
            r_iss_we    <= 1'b0;
            r_iss_addr  <= '0;
            r_iss_wdata <= '0;
        end else begin
            r_iss_own <= w_cpu_win ? OWN_CPU : (w_vid_win ? OWN_VID : OWN_NONE);
            r_iss_we  <= w_cpu_win && cpu_we;
            if (w_cpu_win) begin
                r_iss_addr  <= cpu_addr;
                r_iss_wdata <= cpu_wdata;
            end else if (w_vid_win) begin
                r_iss_addr  <= vid_addr;
            end
        end
    end

    // Stage B: RAM port driven straight from the issue register.
    assign mem_en    = (r_iss_own != OWN_NONE);
    assign mem_we    = r_iss_we;
    assign mem_addr  = r_iss_addr;
    assign mem_wdata = r_iss_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ret_own   <= OWN_NONE;
            r_cpu_rdata <= '0;
            r_vid_rdata <= '0;
        end else begin
            r_ret_own <= r_iss_we ? OWN_NONE : r_iss_own;
            if (cpu_rvalid) r_cpu_rdata <= mem_rdata;
            if (vid_rvalid) r_vid_rdata <= mem_rdata;
        end
    end

    // Stage C: RAM output is passed through while valid to keep gnt->rvalid at 2 cycles,
    // and the hold register keeps rdata stable afterwards.
    assign cpu_rvalid = (r_ret_own == OWN_CPU);
    assign vid_rvalid = (r_ret_own == OWN_VID);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : r_cpu_rdata;
    assign vid_rdata  = vid_rvalid ? mem_rdata : r_vid_rdata;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] r_cpu_stall_cnt;
    logic [15:0] r_vid_gnt_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cpu_stall_cnt <= '0;
            r_vid_gnt_cnt   <= '0;
        end else if (stats_clr) begin
            r_cpu_stall_cnt <= '0;
            r_vid_gnt_cnt   <= '0;
        end else begin
            if (w_starve_inc && (r_cpu_stall_cnt != '1)) r_cpu_stall_cnt <= r_cpu_stall_cnt + 1'b1;
            if (w_vid_win && (r_vid_gnt_cnt != '1))      r_vid_gnt_cnt   <= r_vid_gnt_cnt + 1'b1;
        end
    end

    assign cpu_stall_cnt = r_cpu_stall_cnt;
    assign vid_gnt_cnt   = r_vid_gnt_cnt;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic against a
// transaction-level model (grant rule, grant-ordered memory image, return queue).
module tb_mem_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, vid_req;
    logic [AW-1:0] cpu_addr, vid_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt, cpu_rvalid, vid_gnt, vid_rvalid;
    logic [DW-1:0] cpu_rdata, vid_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
`ifdef MEM_ARB_STATS_EN
    logic          stats_clr;
    logic [15:0]   cpu_stall_cnt, vid_gnt_cnt;
`endif

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_gnt    (vid_gnt),
        .vid_rvalid (vid_rvalid),
        .vid_rdata  (vid_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
`ifdef MEM_ARB_STATS_EN
        ,
        .stats_clr     (stats_clr),
        .cpu_stall_cnt (cpu_stall_cnt),
        .vid_gnt_cnt   (vid_gnt_cnt)
`endif
    );

    // Synchronous single-port RAM, 1-cycle read latency.
    logic [DW-1:0] ram [0:65535];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    typedef struct {
        bit            is_cpu;
        logic [DW-1:0] data;
        int            due;
    } ret_t;

    logic [DW-1:0] ref_mem [0:65535];
    ret_t          rq[$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc      = 0;
    int            starve   = 0;
    bit            m_en, m_we, last_cg, last_vg;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_cpu_rdata, m_vid_rdata;
    int            m_stall, m_vgc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic model_clear();
        rq.delete();
        starve = 0;
        m_en = 0; m_we = 0; m_addr = '0; m_wdata = '0;
        m_cpu_rdata = '0; m_vid_rdata = '0;
        m_stall = 0; m_vgc = 0;
        last_cg = 0; last_vg = 0;
    endtask

    // Entered at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic step();
        bit ecg, evg, ecr, evr;
        #1;
        ecg = cpu_req && (!vid_req || starve == SMAX);
        evg = vid_req && !ecg;
        ecr = (rq.size() > 0) && (rq[0].due == cyc) && rq[0].is_cpu;
        evr = (rq.size() > 0) && (rq[0].due == cyc) && !rq[0].is_cpu;
        if (ecr) m_cpu_rdata = rq[0].data;
        if (evr) m_vid_rdata = rq[0].data;

        chk("cpu_gnt", 32'(cpu_gnt), 32'(ecg));
        chk("vid_gnt", 32'(vid_gnt), 32'(evg));
        chk("mem_en", 32'(mem_en), 32'(m_en));
        chk("mem_we", 32'(mem_we), 32'(m_we));
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        if (m_we) chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(ecr));
        chk("vid_rvalid", 32'(vid_rvalid), 32'(evr));
        chk("cpu_rdata", 32'(cpu_rdata), 32'(m_cpu_rdata));
        chk("vid_rdata", 32'(vid_rdata), 32'(m_vid_rdata));
`ifdef MEM_ARB_STATS_EN
        chk("cpu_stall_cnt", 32'(cpu_stall_cnt), 32'(m_stall));
        chk("vid_gnt_cnt", 32'(vid_gnt_cnt), 32'(m_vgc));
        if (stats_clr) begin
            m_stall = 0; m_vgc = 0;
        end else begin
            if (cpu_req && !ecg && m_stall < 16'hFFFF) m_stall++;
            if (evg && m_vgc < 16'hFFFF) m_vgc++;
        end
`endif
        if (ecr || evr) void'(rq.pop_front());
        if (cpu_req && !ecg) starve = (starve < SMAX) ? starve + 1 : SMAX;
        else                 starve = 0;

        m_en = ecg || evg;
        m_we = ecg && cpu_we;
        if (ecg) begin
            m_addr = cpu_addr;
            if (cpu_we) begin
                m_wdata = cpu_wdata;
                ref_mem[cpu_addr] = cpu_wdata;
            end else begin
                rq.push_back('{is_cpu: 1'b1, data: ref_mem[cpu_addr], due: cyc + 2});
            end
        end else if (evg) begin
            m_addr = vid_addr;
            rq.push_back('{is_cpu: 1'b0, data: ref_mem[vid_addr], due: cyc + 2});
        end
        last_cg = ecg;
        last_vg = evg;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cpu_req = 1'b0; vid_req = 1'b0;
`ifdef MEM_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        #1;
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst_vid_rvalid", 32'(vid_rvalid), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_vid_rdata", 32'(vid_rdata), 32'd0);
        model_clear();
        @(posedge clk);
        cyc++;
        #1;
        reset = 1'b1;
    endtask

    initial begin
        cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; vid_addr = '0;
        for (int i = 0; i < 65536; i++) begin
            ram[i]     = 16'(i) ^ 16'h5A5A;
            ref_mem[i] = 16'(i) ^ 16'h5A5A;
        end
        ram[16'h0010] = 16'hBEEF; ref_mem[16'h0010] = 16'hBEEF;
        for (int i = 0; i < 4; i++) begin
            ram[16'h0100 + i]     = 16'h00A0 + 16'(i);
            ref_mem[16'h0100 + i] = 16'h00A0 + 16'(i);
        end

        @(posedge clk);
        #1;
        do_reset();

        // CPU read of a preloaded word.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        step();
        cpu_req = 1'b0;
        step(); step(); step();

        // Write then read-back of the same address on consecutive grants.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'h1234;
        step();
        cpu_we = 1'b0;
        step();
        cpu_req = 1'b0;
        step(); step(); step();

        // Continuous contention: video wins SMAX times, then the CPU.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
        vid_req = 1'b1; vid_addr = 16'h0030;
        for (int i = 0; i < 3 * (SMAX + 1); i++) step();
        cpu_req = 1'b0; vid_req = 1'b0;
        step(); step(); step();

        // Back-to-back video stream.
        vid_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vid_addr = 16'h0100 + 16'(i);
            step();
        end
        vid_req = 1'b0;
        step(); step(); step();

        // Reset one cycle after a CPU read grant drops the access.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        step();
        do_reset();
        step(); step(); step();
        cpu_req = 1'b1; vid_req = 1'b1; vid_addr = 16'h0101;
        for (int i = 0; i < SMAX + 2; i++) step();
        cpu_req = 1'b0; vid_req = 1'b0;
        step(); step();

        // Random traffic honouring the hold-until-granted handshake.
        for (int i = 0; i < 400; i++) begin
            if (!cpu_req || last_cg) begin
                cpu_req   = ($urandom_range(0, 3) != 0);
                cpu_we    = ($urandom_range(0, 2) == 0);
                cpu_addr  = 16'($urandom_range(0, 15));
                cpu_wdata = 16'($urandom);
            end
            if (!vid_req || last_vg) begin
                vid_req  = ($urandom_range(0, 2) != 0);
                vid_addr = 16'($urandom_range(0, 15));
            end
`ifdef MEM_ARB_STATS_EN
            stats_clr = (i == 200) || (i == 333);
`endif
            step();
        end
        cpu_req = 1'b0; vid_req = 1'b0;
`ifdef MEM_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        step(); step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single-port synchronous block RAM between two requesters: the CPU datapath (instruction fetch, LOAD, STOR) and the video scan-out reader (read-only framebuffer fetch).
- Fixed priority favours video.
- A CPU starvation counter bounds CPU wait.
- Sits between the control FSM/datapath memory signals and the RAM, so CPU memory access becomes a req/gnt handshake.

Parameters:
ADDR_W, 16, address width for all ports
DATA_W, 16, data width
STARVE_MAX, 4, consecutive denied CPU cycles before the CPU is forced to win (1..15)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU access request
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  accept; combinational, same cycle as winning req
cpu_rvalid  out  1  CPU read data valid
cpu_rdata  out  DATA_W  CPU read data
vid_req  in  1  video read request
vid_addr  in  ADDR_W  video address
vid_gnt  out  1  accept; combinational
vid_rvalid  out  1  video read data valid
vid_rdata  out  DATA_W  video read data
mem_en  out  1  RAM access enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, 1-cycle latency after mem_en

Behaviour:
- Reset (reset=0, async):
  - Issue register and return tag invalid; starve_cnt=0.
  - mem_en, mem_we, cpu_rvalid and vid_rvalid are 0.
  - mem_addr, mem_wdata, cpu_rdata and vid_rdata are 0.
  - Reset mid-access drops any in-flight access; no rvalid follows reset release.
- Handshake is valid/ready:
  - The requester holds req, addr, we and wdata until gnt=1 in the same cycle.
  - After gnt it may change them or present a new request next cycle.
  - One grant per cycle max; back-to-back grants are allowed every cycle.
- Arbitration, cycle k:
  - Only vid_req → vid wins.
  - Only cpu_req → cpu wins.
  - Both → vid wins, unless starve_cnt==STARVE_MAX, then cpu wins.
- starve_cnt:
  - +1 each cycle cpu_req=1 and cpu_gnt=0, saturating at STARVE_MAX.
  - Cleared on cpu_gnt or cpu_req=0.
- Pipeline:
  - Stage A (cycle k): grant; winner's addr/we/wdata and owner tag (OWN_CPU/OWN_VID) are registered.
  - Stage B (k+1): mem_en=1, mem_addr/mem_we/mem_wdata driven from the registers. Video accesses always have mem_we=0.
  - Stage C (k+2): for reads, the owner's rvalid=1 for one cycle and its rdata=mem_rdata, registered.
  - Writes produce no rvalid.
- Idle:
  - No grant in k → mem_en=0, mem_we=0 at k+1.
  - mem_addr and mem_wdata hold their last value.
- Ordering:
  - Returns are in issue order.
  - A read issued after a write to the same address returns the new data.
- rdata outputs hold their last value when rvalid=0.
- Read latency from gnt to rvalid is exactly 2 cycles; throughput is 1 access/cycle.

Optional Feature:
MEM_ARB_STATS_EN:
- When defined, adds:
  - input stats_clr (1 bit)
  - output cpu_stall_cnt (16 bits): counts cycles with cpu_req & !cpu_gnt
  - output vid_gnt_cnt (16 bits): counts vid grants
- Both counters saturate at 0xFFFF.
- Both are cleared by reset or by stats_clr; stats_clr has priority over an increment in the same cycle.
- When not defined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg holds:
  - the owner enum OWN_NONE/OWN_CPU/OWN_VID (2 bits)
  - ADDR_W and DATA_W default constants
  - STARVE_CNT_W=4
- One sub-module, arb_starve_counter: saturating counter with inc/clr/at_max.

Test Plan:
1. CPU read only: cpu_req, addr 0x0010, RAM[0x0010]=0xBEEF → cpu_gnt cycle 0; mem_en=1, mem_addr=0x0010 cycle 1; cpu_rvalid=1, cpu_rdata=0xBEEF cycle 2.
2. CPU write 0x0020←0x1234, then read 0x0020 next cycle → mem_we=1 cycle 1 with no cpu_rvalid; read returns 0x1234 at cycle 3.
3. Both requests held continuously, STARVE_MAX=4 → grant sequence V,V,V,V,C repeating; starve_cnt never exceeds 4.
4. Video alone, back-to-back 0x0100..0x0103 holding 0xA0..0xA3 → vid_gnt cycles 0–3; vid_rvalid cycles 2–5 with data 0xA0..0xA3 in order.
5. CPU read granted cycle 0, reset=0 during cycle 1 → mem_en=0, no cpu_rvalid after release, starve_cnt=0.
6. MEM_ARB_STATS_EN: CPU denied 3 cycles while video streams → cpu_stall_cnt=3; pulse stats_clr → 0 next cycle.
